stream_mux: RTL and testbench

//  - Parametrised N-channel registered stream multiplexer with a valid/ready handshake on every port.
//  - Generalises the fixed 8:1 combinational mux: any channel count and width, and a registered output.
//  - Arbitration is either by an explicit select or round-robin.
//  - Feeds shared datapaths, e.g. writeback-bus sources and memory-port requesters.

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/stream_mux_rr_arbiter.sv | 33 +++
 rtl/stream_mux.sv | 167 ++++++++++++++++
 tb/tb_stream_mux.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared arbitration-mode constants and width helper for stream_mux.
package stream_mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (rotate by ptr, lowest-index priority, un-rotate).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int C  = 8,
  parameter int SW = clog2_min1(C)
) (
  input  logic [C-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*C-1:0] dbl;
  logic [C-1:0]   rot;
  int             pick;
  int             sum;

  // Rotate so ptr sits at bit 0, take the first request, map back to a channel index
  always_comb begin
    dbl     = {req, req};
    rot     = C'(dbl >> ptr);
    gnt_any = |req;
    pick    = 0;
    for (int i = C - 1; i >= 0; i--) begin
      if (rot[i]) pick = i;
    end
    sum = pick + int'(ptr);
    if (sum >= C) sum = sum - C;
    gnt_idx = SW'(sum);
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel registered stream multiplexer with valid/ready on every port.
// Grant is by explicit sel (MODE_SELECT) or round-robin (MODE_RR).
// Build macro STREAM_MUX_LAST_LOCK_EN adds in_last/out_last and holds the grant for a whole packet.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int W    = 32,
  parameter int C    = 8,
  parameter int MODE = MODE_SELECT,
  parameter int SW   = clog2_min1(C)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [C*W-1:0] in_data,
  input  logic [C-1:0]   in_valid,
  output logic [C-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
`ifdef STREAM_MUX_LAST_LOCK_EN
  ,
  input  logic [C-1:0]   in_last,
  output logic           out_last
`endif
);

  logic          load;
  logic          xfer;
  logic [SW-1:0] arb_idx;
  logic          arb_any;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic [W-1:0]  gnt_data;
  logic          err_now;
  logic          vld_p1;
  logic [W-1:0]  data_p1;
  logic [SW-1:0] ch_p1;
  logic          err_p1;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic          gnt_last;
  logic          last_p1;
  logic          lock;
  logic [SW-1:0] lock_ch;
`endif

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] rr_ptr;
      logic          ptr_adv;

      rr_arbiter #(.C(C), .SW(SW)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
      );

`ifdef STREAM_MUX_LAST_LOCK_EN
      assign ptr_adv = xfer && gnt_last;
`else
      assign ptr_adv = xfer;
`endif

      // Round-robin pointer moves just past the winner once its beat (or packet end) is accepted
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_ptr <= '0;
        end else if (ptr_adv) begin
          rr_ptr <= (gnt_idx == SW'(C - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end else begin : g_sel
      // Explicit select: an out-of-range sel matches no channel, so nothing is granted
      always_comb begin
        arb_idx = sel;
        arb_any = 1'b0;
        for (int i = 0; i < C; i++) begin
          if (sel == SW'(i)) arb_any = in_valid[i];
        end
      end
    end
  endgenerate

  // Final grant: an open packet keeps its channel regardless of sel or rr_ptr
  always_comb begin
    gnt_idx = arb_idx;
    gnt_any = arb_any;
`ifdef STREAM_MUX_LAST_LOCK_EN
    if (lock) begin
      gnt_idx = lock_ch;
      gnt_any = 1'b0;
      for (int i = 0; i < C; i++) begin
        if (lock_ch == SW'(i)) gnt_any = in_valid[i];
      end
    end
`endif
  end

  // Handshake: accept only when the output register is free or draining this cycle
  always_comb begin
    load     = !vld_p1 || out_ready;
    xfer     = load && gnt_any;
    gnt_data = '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
    gnt_last = 1'b0;
`endif
    for (int i = 0; i < C; i++) begin
      in_ready[i] = xfer && (gnt_idx == SW'(i));
      if (gnt_idx == SW'(i)) begin
        gnt_data = in_data[i*W +: W];
`ifdef STREAM_MUX_LAST_LOCK_EN
        gnt_last = in_last[i];
`endif
      end
    end
    err_now = (MODE == MODE_SELECT) && (int'(sel) >= C) && (|in_valid);
  end

  // Stage p1: output register, loads a granted beat or empties when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      err_p1  <= 1'b0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      last_p1 <= 1'b0;
`endif
    end else begin
      err_p1 <= err_now;
      if (load) begin
        vld_p1 <= xfer;
        if (xfer) begin
          data_p1 <= gnt_data;
          ch_p1   <= gnt_idx;
`ifdef STREAM_MUX_LAST_LOCK_EN
          last_p1 <= gnt_last;
`endif
        end
      end
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  // Packet lock: set by an accepted non-last beat, cleared by an accepted last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock    <= !gnt_last;
      lock_ch <= gnt_idx;
    end
  end

  assign out_last = last_p1;
`endif

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign sel_err   = err_p1;

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: three stream_mux instances (SELECT C=8, SELECT C=6, RR C=4) against a
// queue-free behavioural model; packet-lock scenarios run when STREAM_MUX_LAST_LOCK_EN is defined.
module tb_stream_mux;

  localparam int NI = 3;
`ifdef STREAM_MUX_LAST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] dat [NI][8];
  logic [7:0]  vld [NI];
  logic [7:0]  lst [NI];
  logic [2:0]  sel [NI];
  logic        rdy [NI];

  logic [255:0] d0;
  logic [191:0] d1;
  logic [127:0] d2;

  logic [7:0]  ir0;
  logic [5:0]  ir1;
  logic [3:0]  ir2;
  logic [31:0] od0, od1, od2;
  logic [2:0]  oc0, oc1;
  logic [1:0]  oc2;
  logic        ov0, ov1, ov2;
  logic        er0, er1, er2;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic        ol0, ol1, ol2;
`endif

  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 1'b0;

  always_comb begin
    for (int i = 0; i < 8; i++) d0[i*32 +: 32] = dat[0][i];
    for (int i = 0; i < 6; i++) d1[i*32 +: 32] = dat[1][i];
    for (int i = 0; i < 4; i++) d2[i*32 +: 32] = dat[2][i];
  end

  stream_mux #(.W(32), .C(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(vld[0]), .in_ready(ir0),
    .sel(sel[0]), .out_data(od0), .out_ch(oc0), .out_valid(ov0), .out_ready(rdy[0]),
    .sel_err(er0)
`ifdef STREAM_MUX_LAST_LOCK_EN
    , .in_last(lst[0]), .out_last(ol0)
`endif
  );

  stream_mux #(.W(32), .C(6), .MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(vld[1][5:0]), .in_ready(ir1),
    .sel(sel[1]), .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(rdy[1]),
    .sel_err(er1)
`ifdef STREAM_MUX_LAST_LOCK_EN
    , .in_last(lst[1][5:0]), .out_last(ol1)
`endif
  );

  stream_mux #(.W(32), .C(4), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(vld[2][3:0]), .in_ready(ir2),
    .sel(sel[2][1:0]), .out_data(od2), .out_ch(oc2), .out_valid(ov2), .out_ready(rdy[2]),
    .sel_err(er2)
`ifdef STREAM_MUX_LAST_LOCK_EN
    , .in_last(lst[2][3:0]), .out_last(ol2)
`endif
  );

  // ---------------- behavioural model ----------------
  bit          m_ov   [NI];
  logic [31:0] m_od   [NI];
  int          m_och  [NI];
  bit          m_err  [NI];
  int          m_ptr  [NI];
  bit          m_lock [NI];
  int          m_lch  [NI];
  bit          m_last [NI];

  function automatic int cc(int k);
    return (k == 0) ? 8 : (k == 1) ? 6 : 4;
  endfunction

  function automatic int cm(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int m_grant(int k);
    int c;
    c = cc(k);
    if (LOCK && m_lock[k]) return vld[k][m_lch[k]] ? m_lch[k] : -1;
    if (cm(k) == 0) begin
      if (int'(sel[k]) < c && vld[k][sel[k]]) return int'(sel[k]);
      return -1;
    end
    for (int j = 0; j < c; j++) begin
      if (vld[k][(m_ptr[k] + j) % c]) return (m_ptr[k] + j) % c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_ready(int k);
    int g;
    g = m_grant(k);
    if ((!m_ov[k] || rdy[k]) && g >= 0) return 8'(1 << g);
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_ov[k] = 0; m_od[k] = '0; m_och[k] = 0; m_err[k] = 0;
        m_ptr[k] = 0; m_lock[k] = 0; m_lch[k] = 0; m_last[k] = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int g;
        bit ld;
        g  = m_grant(k);
        ld = !m_ov[k] || rdy[k];
        m_err[k] = (cm(k) == 0) && (int'(sel[k]) >= cc(k)) && (vld[k] != 8'h00);
        if (ld) begin
          if (g >= 0) begin
            m_ov[k]   = 1;
            m_od[k]   = dat[k][g];
            m_och[k]  = g;
            m_last[k] = lst[k][g];
            if (LOCK) begin
              m_lock[k] = !lst[k][g];
              m_lch[k]  = g;
            end
            if (cm(k) == 1 && (!LOCK || lst[k][g])) m_ptr[k] = (g + 1) % cc(k);
          end else begin
            m_ov[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- DUT accessors ----------------
  function automatic logic [7:0] d_ir(int k);
    return (k == 0) ? ir0 : (k == 1) ? {2'b00, ir1} : {4'h0, ir2};
  endfunction
  function automatic logic [31:0] d_od(int k);
    return (k == 0) ? od0 : (k == 1) ? od1 : od2;
  endfunction
  function automatic int d_oc(int k);
    return (k == 0) ? int'(oc0) : (k == 1) ? int'(oc1) : int'(oc2);
  endfunction
  function automatic logic d_ov(int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction
  function automatic logic d_er(int k);
    return (k == 0) ? er0 : (k == 1) ? er1 : er2;
  endfunction
`ifdef STREAM_MUX_LAST_LOCK_EN
  function automatic logic d_ol(int k);
    return (k == 0) ? ol0 : (k == 1) ? ol1 : ol2;
  endfunction
`endif

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s u%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("in_ready", k, 64'(d_ir(k)), 64'(m_ready(k)));
        chk("out_valid", k, 64'(d_ov(k)), 64'(m_ov[k]));
        chk("sel_err", k, 64'(d_er(k)), 64'(m_err[k]));
        if (m_ov[k]) begin
          chk("out_data", k, 64'(d_od(k)), 64'(m_od[k]));
          chk("out_ch", k, 64'(d_oc(k)), 64'(m_och[k]));
`ifdef STREAM_MUX_LAST_LOCK_EN
          chk("out_last", k, 64'(d_ol(k)), 64'(m_last[k]));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    for (int k = 0; k < NI; k++) begin
      vld[k] = 8'h00;
      lst[k] = 8'hFF;
      sel[k] = 3'd0;
      rdy[k] = 1'b1;
      for (int i = 0; i < 8; i++) dat[k][i] = 32'hA000_0000 | 32'(k << 8) | 32'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] hold_d;
    idle();
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Reset state
    chk("rst_out_valid", 0, 64'(ov0), 64'd0);
    chk("rst_out_data", 0, 64'(od0), 64'd0);
    chk("rst_out_ch", 0, 64'(oc0), 64'd0);
    chk("rst_sel_err", 0, 64'(er0), 64'd0);
    chk("rst_out_valid", 2, 64'(ov2), 64'd0);

    // Test 1: MODE0 C=8, sel=3
    sel[0] = 3'd3; vld[0] = 8'h08; dat[0][3] = 32'hDEAD0003;
    #2 chk("t1_in_ready", 0, 64'(ir0), 64'h08);
    tick();
    chk("t1_out_valid", 0, 64'(ov0), 64'd1);
    chk("t1_out_data", 0, 64'(od0), 64'hDEAD0003);
    chk("t1_out_ch", 0, 64'(oc0), 64'd3);
    vld[0] = 8'h00;
    tick();
    chk("t1_drain", 0, 64'(ov0), 64'd0);

    // Test 2: MODE0 C=6, sel out of range
    sel[1] = 3'd7; vld[1] = 8'h3F;
    #2 chk("t2_in_ready", 1, 64'(ir1), 64'h00);
    tick();
    chk("t2_sel_err", 1, 64'(er1), 64'd1);
    chk("t2_out_valid", 1, 64'(ov1), 64'd0);
    vld[1] = 8'h00;
    tick();
    chk("t2_err_pulse", 1, 64'(er1), 64'd0);
    sel[1] = 3'd0;

    // Test 3: MODE1 C=4, all valid, back-to-back rotation
    vld[2] = 8'h0F;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t3_out_valid", 2, 64'(ov2), 64'd1);
      chk("t3_out_ch", 2, 64'(oc2), 64'(j % 4));
    end

    // Test 4: backpressure holds the output and blocks acceptance
    rdy[2] = 1'b0;
    hold_d = od2;
    for (int j = 0; j < 3; j++) begin
      #2 chk("t4_in_ready_hold", 2, 64'(ir2), 64'h0);
      tick();
      chk("t4_ch_hold", 2, 64'(oc2), 64'd3);
      chk("t4_data_hold", 2, 64'(od2), 64'(hold_d));
    end
    rdy[2] = 1'b1;
    #2 chk("t4_reload_ready", 2, 64'(ir2), 64'h1);
    tick();
    chk("t4_reload_ch", 2, 64'(oc2), 64'd0);
    vld[2] = 8'h00;
    tick();

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Test 5: packet lock in RR mode, ch2 packet with a gap, ch0 valid throughout
    vld[2] = 8'h02;
    tick();
    chk("t5_pre_ch", 2, 64'(oc2), 64'd1);
    vld[2] = 8'h05; lst[2] = 8'hFB;
    #2 chk("t5_first_ready", 2, 64'(ir2), 64'h4);
    tick();
    chk("t5_beat1_ch", 2, 64'(oc2), 64'd2);
    vld[2] = 8'h01;
    #2 chk("t5_gap_ready", 2, 64'(ir2), 64'h0);
    tick();
    chk("t5_gap_valid", 2, 64'(ov2), 64'd0);
    vld[2] = 8'h05;
    tick();
    chk("t5_beat2_ch", 2, 64'(oc2), 64'd2);
    lst[2] = 8'hFF;
    tick();
    chk("t5_beat3_ch", 2, 64'(oc2), 64'd2);
    chk("t5_beat3_last", 2, 64'(ol2), 64'd1);
    tick();
    chk("t5_after_ch", 2, 64'(oc2), 64'd0);
    lst[2] = 8'hFB;
    tick();
    chk("t5_relock_ch", 2, 64'(oc2), 64'd2);
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_valid", 2, 64'(ov2), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("t5_post_rst_ch", 2, 64'(oc2), 64'd0);
    idle();
    tick();
`endif

    // Test 6: asynchronous reset between edges while holding a beat
    vld[0] = 8'h01; sel[0] = 3'd0;
    tick();
    chk("t6_pre_valid", 0, 64'(ov0), 64'd1);
    vld[0] = 8'h00; rdy[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("t6_async_valid", 0, 64'(ov0), 64'd0);
    chk("t6_async_data", 0, 64'(od0), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    rdy[0] = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
